// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_ctrl
// Desc   : VGA pixel-tick divider, h/v scan counters, sync/video decode and
//          frame-aligned start/stop sequencing.
// Rev    : 1.0  initial release
// ============================================================================
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_DIV   = 4,
  parameter bit SYNC_POL  = 1'b0,
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_stop,
  output logic          o_busy,
  output logic          o_pix_tick,
  output logic [HW-1:0] o_hcnt,
  output logic [VW-1:0] o_vcnt,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic          o_line_end,
  output logic          o_frame_start,
  output logic          o_frame_done
);

  localparam int DW = $clog2(PIX_DIV);

  localparam logic [DW-1:0] c_div_last = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] c_h_last   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] c_v_last   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] c_h_vis    = HW'(H_VISIBLE);
  localparam logic [VW-1:0] c_v_vis    = VW'(V_VISIBLE);
  localparam logic [HW-1:0] c_hs_first = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] c_hs_last  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] c_vs_first = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] c_vs_last  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [VW-1:0] r_vcnt, w_vcnt_nxt;
  logic          r_hsync, r_vsync, r_video_on;
  logic          r_line_end, r_frame_start, r_frame_done;
  logic          w_tick, w_hwrap, w_fwrap, w_busy_nxt;
  logic          w_hsync_nxt, w_vsync_nxt, w_video_nxt;
  logic          w_line_end_nxt, w_frame_start_nxt, w_frame_done_nxt;

  always_comb begin
    w_tick            = (r_state != S_IDLE) && (r_div == c_div_last);
    w_hwrap           = w_tick && (r_hcnt == c_h_last);
    w_fwrap           = w_hwrap && (r_vcnt == c_v_last);
    w_state_nxt       = r_state;
    w_div_nxt         = r_div;
    w_hcnt_nxt        = r_hcnt;
    w_vcnt_nxt        = r_vcnt;
    w_line_end_nxt    = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_frame_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt       = S_RUN;
          w_frame_start_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (i_stop) w_state_nxt = S_STOPPING;
      end
      S_STOPPING: begin
        // A start on the final wrap tick keeps the scan running.
        if (i_start)      w_state_nxt = S_RUN;
        else if (w_fwrap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (r_state == S_IDLE) begin
      if (i_start) begin
        w_div_nxt  = '0;
        w_hcnt_nxt = '0;
        w_vcnt_nxt = '0;
      end
    end else begin
      w_div_nxt = w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        w_hcnt_nxt = w_hwrap ? '0 : r_hcnt + HW'(1);
        if (w_hwrap) w_vcnt_nxt = w_fwrap ? '0 : r_vcnt + VW'(1);
        w_line_end_nxt    = w_hwrap;
        w_frame_start_nxt = w_fwrap && (w_state_nxt != S_IDLE);
        w_frame_done_nxt  = w_fwrap && (w_state_nxt == S_IDLE);
      end
    end

    // Decode from next-state counters so syncs line up with hcnt/vcnt.
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_hsync_nxt = (w_busy_nxt && (w_hcnt_nxt >= c_hs_first) && (w_hcnt_nxt <= c_hs_last))
                  ? SYNC_POL : ~SYNC_POL;
    w_vsync_nxt = (w_busy_nxt && (w_vcnt_nxt >= c_vs_first) && (w_vcnt_nxt <= c_vs_last))
                  ? SYNC_POL : ~SYNC_POL;
    w_video_nxt = w_busy_nxt && (w_hcnt_nxt < c_h_vis) && (w_vcnt_nxt < c_v_vis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_line_end    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div         <= w_div_nxt;
      r_hcnt        <= w_hcnt_nxt;
      r_vcnt        <= w_vcnt_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_nxt;
      r_line_end    <= w_line_end_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_done  <= w_frame_done_nxt;
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_pix_tick    = w_tick;
  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_line_end    = r_line_end;
  assign o_frame_start = r_frame_start;
  assign o_frame_done  = r_frame_done;

endmodule
`default_nettype wire
